// File: rtl/composite_pkg.sv
// Constants and types shared by the line-buffer BRAM wrapper, the pixel reader and the
// composite luma/sync encoder.
package composite_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 4;
    localparam int LEN_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } pix_entry_t;

    localparam pix_entry_t ENTRY_ZERO = '{last: 1'b0, data: {DATA_W{1'b0}}};

    // Line-buffer addresses wrap modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Small register FIFO of {last, data} pixel entries; entry 0 is the registered head
// driven straight onto the output stream. Flush empties it in one cycle.
module pix_skid_fifo
    import composite_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  pix_entry_t       din,
    input  logic             pop,
    output pix_entry_t       head,
    output logic             head_vld,
    output logic [CNT_W-1:0] count
);

    pix_entry_t       mem_r   [DEPTH];
    pix_entry_t       shift_s [DEPTH];
    pix_entry_t       mem_s   [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] wr_idx_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Next-state storage: pop shifts toward the head, push lands behind the survivors.
    always_comb begin
        pop_ok_s  = pop & (count_r != {CNT_W{1'b0}});
        wr_idx_s  = count_r - CNT_W'(pop_ok_s);
        push_ok_s = push & (wr_idx_s < CNT_W'(DEPTH));
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_s[i] = pop_ok_s ? mem_r[i+1] : mem_r[i];
        end
        shift_s[DEPTH-1] = pop_ok_s ? ENTRY_ZERO : mem_r[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            mem_s[i] = (push_ok_s && (wr_idx_s == CNT_W'(i))) ? din : shift_s[i];
        end
        count_s = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ENTRY_ZERO;
            end
            count_r <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= mem_s[i];
            end
            count_r <= count_s;
        end
    end

    assign head     = mem_r[0];
    assign head_vld = (count_r != {CNT_W{1'b0}});
    assign count    = count_r;

endmodule

// File: rtl/line_pixel_reader.sv
// Streams one line of 4-bit pixels out of the line-buffer BRAM into a valid/ready stream,
// issuing reads only when the skid FIFO has guaranteed room for their data.
module line_pixel_reader
    import composite_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] line_base,
    input  logic [LEN_W-1:0]  line_len,
    output logic              busy,
    output logic              line_done,
    output logic              ram_ceb,
    output logic [ADDR_W-1:0] ram_adb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);

    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + READ_LAT + 1) + 1;

    rd_state_t         state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] adb_hold_r;
    logic [LEN_W-1:0]  remain_r;
    logic [READ_LAT-1:0] lat_vld_r;
    logic [READ_LAT-1:0] lat_last_r;
    logic              line_done_r;

    logic [FCNT_W-1:0] fifo_count_s;
    logic [CNT_W-1:0]  inflight_s;
    logic [CNT_W-1:0]  credit_s;
    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic              issue_last_s;
    pix_entry_t        head_s;
    logic              head_vld_s;
    pix_entry_t        push_entry_s;

    // Credit check: FIFO occupancy plus reads still in the BRAM pipe, net of this cycle's pop.
    always_comb begin
        inflight_s = {CNT_W{1'b0}};
        for (int i = 0; i < READ_LAT; i++) begin
            inflight_s = inflight_s + CNT_W'(lat_vld_r[i]);
        end
        pop_s    = head_vld_s & pix_ready;
        credit_s = CNT_W'(fifo_count_s) + inflight_s - CNT_W'(pop_s);
        if ((state_r == FETCH) && !line_start && (credit_s < CNT_W'(FIFO_DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        issue_last_s = issue_s & (remain_r == LEN_W'(1));
    end

    // A new line_start discards whatever the old line still has in the read pipe.
    assign push_s       = lat_vld_r[READ_LAT-1] & ~line_start;
    assign push_entry_s = '{last: lat_last_r[READ_LAT-1], data: ram_doutb};

    // Line sequencing, read address/length tracking and the read-latency pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            adb_hold_r  <= {ADDR_W{1'b0}};
            remain_r    <= {LEN_W{1'b0}};
            lat_vld_r   <= {READ_LAT{1'b0}};
            lat_last_r  <= {READ_LAT{1'b0}};
            line_done_r <= 1'b0;
        end else begin
            line_done_r   <= 1'b0;
            lat_vld_r[0]  <= issue_s;
            lat_last_r[0] <= issue_last_s;
            for (int i = 1; i < READ_LAT; i++) begin
                lat_vld_r[i]  <= lat_vld_r[i-1] & ~line_start;
                lat_last_r[i] <= lat_last_r[i-1] & ~line_start;
            end
            if (issue_s) begin
                addr_r     <= addr_inc(addr_r);
                remain_r   <= remain_r - LEN_W'(1);
                adb_hold_r <= addr_r;
            end
            if (line_start) begin
                if (line_len != {LEN_W{1'b0}}) begin
                    state_r  <= FETCH;
                    addr_r   <= line_base;
                    remain_r <= line_len;
                end else begin
                    state_r     <= IDLE;
                    line_done_r <= 1'b1;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    FETCH: begin
                        if (issue_last_s) begin
                            state_r <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (pop_s && head_s.last) begin
                            state_r     <= IDLE;
                            line_done_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    pix_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (line_start),
        .push     (push_s),
        .din      (push_entry_s),
        .pop      (pop_s),
        .head     (head_s),
        .head_vld (head_vld_s),
        .count    (fifo_count_s)
    );

    assign busy      = (state_r != IDLE);
    assign line_done = line_done_r;
    assign ram_ceb   = issue_s;
    assign ram_adb   = issue_s ? addr_r : adb_hold_r;
    assign pix_data  = head_s.data;
    assign pix_valid = head_vld_s;
    assign pix_last  = head_s.last;

endmodule

// File: tb/tb_line_pixel_reader.sv
// Directed bench for line_pixel_reader with a behavioural 1-cycle BRAM and a
// negedge monitor that records issued addresses, accepted pixels and line_done pulses.
module tb_line_pixel_reader;
    import composite_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              line_start = 1'b0;
    logic [ADDR_W-1:0] line_base = 9'd0;
    logic [LEN_W-1:0]  line_len = 10'd0;
    logic              busy;
    logic              line_done;
    logic              ram_ceb;
    logic [ADDR_W-1:0] ram_adb;
    logic [DATA_W-1:0] ram_doutb = 4'd0;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready = 1'b1;
    logic              pix_last;

    always #5 clk = ~clk;

    line_pixel_reader dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .line_base  (line_base),
        .line_len   (line_len),
        .busy       (busy),
        .line_done  (line_done),
        .ram_ceb    (ram_ceb),
        .ram_adb    (ram_adb),
        .ram_doutb  (ram_doutb),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last)
    );

    // RAM contents: low half holds addr[3:0]+1, high half holds addr[3:0]+9.
    function automatic logic [3:0] mem_word(input logic [8:0] a);
        return a[8] ? (a[3:0] + 4'd9) : (a[3:0] + 4'd1);
    endfunction

    always @(posedge clk) begin
        if (ram_ceb) ram_doutb <= mem_word(ram_adb);
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int          cyc = 0;
    int          adr_q[$];
    int          adr_cyc[$];
    int          pix_q[$];
    int          pix_cyc[$];
    int          last_cnt, last_cyc, done_cnt, done_cyc;
    int          issued, popped, max_out;
    logic [31:0] busy_mask;
    logic        stalled = 1'b0;
    logic [3:0]  held_data = 4'd0;
    logic        held_last = 1'b0;

    task automatic clear_mon();
        adr_q.delete(); adr_cyc.delete(); pix_q.delete(); pix_cyc.delete();
        last_cnt = 0; last_cyc = -1; done_cnt = 0; done_cyc = -1;
        issued = 0; popped = 0; max_out = 0; busy_mask = 32'd0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (stalled) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_data", pix_data, held_data);
                chk("stall_last", pix_last, held_last);
            end
            stalled   = pix_valid && !pix_ready;
            held_data = pix_data;
            held_last = pix_last;
            if (ram_ceb) begin
                adr_q.push_back(ram_adb); adr_cyc.push_back(cyc); issued++;
            end
            if (pix_valid && pix_ready) begin
                pix_q.push_back(pix_data); pix_cyc.push_back(cyc); popped++;
                if (pix_last) begin last_cnt++; last_cyc = cyc; end
            end
            if (line_done) begin done_cnt++; done_cyc = cyc; end
            if (issued - popped > max_out) max_out = issued - popped;
            if (busy && cyc >= 0 && cyc < 32) busy_mask[cyc] = 1'b1;
        end
    end

    task automatic step(input int c, input logic ls, input logic [8:0] base,
                        input logic [9:0] len, input logic rdy, input logic rst);
        @(posedge clk);
        #1;
        cyc = c; line_start = ls; line_base = base; line_len = len;
        pix_ready = rdy; reset = rst;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating.
    task automatic run_line(input logic [8:0] base, input logic [9:0] len, input int ncyc,
                            input int mode);
        clear_mon();
        for (int c = 0; c < ncyc; c++) begin
            step(c, (c == 0), base, len, (mode == 0) || (c % 4 == 0) || (c % 4 == 3), 1'b0);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_stream(input string t, input int ea[$], input int ep[$]);
        chk({t, "_nadr"}, adr_q.size(), ea.size());
        foreach (ea[i]) chk($sformatf("%s_adr%0d", t, i), (i < adr_q.size()) ? adr_q[i] : -1, ea[i]);
        chk({t, "_npix"}, pix_q.size(), ep.size());
        foreach (ep[i]) chk($sformatf("%s_pix%0d", t, i), (i < pix_q.size()) ? pix_q[i] : -1, ep[i]);
    endtask

    task automatic check_reset_outputs(input string t);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_done"}, line_done, 0);
        chk({t, "_ceb"}, ram_ceb, 0);
        chk({t, "_adb"}, ram_adb, 0);
        chk({t, "_valid"}, pix_valid, 0);
        chk({t, "_last"}, pix_last, 0);
        chk({t, "_data"}, pix_data, 0);
    endtask

    int ea[$];
    int ep[$];
    int none[$];

    initial begin
        clear_mon();
        for (int c = 0; c < 3; c++) step(-1, 1'b0, 9'd0, 10'd0, 1'b1, 1'b1);
        step(-1, 1'b0, 9'd0, 10'd0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check_reset_outputs("rst");

        // Basic line at 0x010, full throughput.
        run_line(9'h010, 10'd4, 10, 0);
        ea = '{16, 17, 18, 19}; ep = '{1, 2, 3, 4};
        check_stream("basic", ea, ep);
        chk("basic_adr_cyc0", (adr_cyc.size() > 0) ? adr_cyc[0] : -1, 1);
        chk("basic_pix_cyc0", (pix_cyc.size() > 0) ? pix_cyc[0] : -1, 3);
        chk("basic_pix_cyc3", (pix_cyc.size() > 3) ? pix_cyc[3] : -1, 6);
        chk("basic_last_cnt", last_cnt, 1);
        chk("basic_last_cyc", last_cyc, 6);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_done_cyc", done_cyc, 7);
        chk("basic_busy", busy_mask, 32'h7E);

        // Same line under backpressure.
        run_line(9'h010, 10'd4, 14, 1);
        check_stream("bp", ea, ep);
        chk("bp_last_cnt", last_cnt, 1);
        chk("bp_done_cnt", done_cnt, 1);
        chk("bp_max_outstanding", max_out, 2);
        chk("bp_busy_end", busy, 0);

        // Address wrap across 0x1FF.
        run_line(9'h1FE, 10'd4, 10, 0);
        ea = '{510, 511, 0, 1}; ep = '{7, 8, 1, 2};
        check_stream("wrap", ea, ep);
        chk("wrap_last_cyc", last_cyc, 6);

        // Zero-length line.
        run_line(9'h040, 10'd0, 6, 0);
        check_stream("zero", none, none);
        chk("zero_busy", busy_mask, 0);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_done_cyc", done_cyc, 1);

        // Abort: second line_start on cycle 4.
        clear_mon();
        for (int c = 0; c < 14; c++) begin
            step(c, (c == 0) || (c == 4), (c == 4) ? 9'h100 : 9'h000,
                 (c == 4) ? 10'd2 : 10'd8, 1'b1, 1'b0);
        end
        @(negedge clk);
        #1;
        ea = '{0, 1, 2, 256, 257}; ep = '{1, 2, 9, 10};
        check_stream("abort", ea, ep);
        chk("abort_new_adr_cyc", (adr_cyc.size() > 3) ? adr_cyc[3] : -1, 5);
        chk("abort_new_pix_cyc", (pix_cyc.size() > 2) ? pix_cyc[2] : -1, 7);
        chk("abort_last_cnt", last_cnt, 1);
        chk("abort_last_cyc", last_cyc, 8);
        chk("abort_done_cnt", done_cnt, 1);
        chk("abort_done_cyc", done_cyc, 9);

        // Reset on cycle 3 of a len=8 line.
        clear_mon();
        for (int c = 0; c < 5; c++) begin
            step(c, (c == 0), 9'h020, 10'd8, 1'b1, (c == 3));
        end
        @(negedge clk);
        #1;
        check_reset_outputs("midrst");
        run_line(9'h010, 10'd4, 10, 0);
        ea = '{16, 17, 18, 19}; ep = '{1, 2, 3, 4};
        check_stream("postrst", ea, ep);
        chk("postrst_done_cyc", done_cyc, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
